// File: rtl/nrdiv_pkg.sv
// Shared types and constants for the non-restoring divider.
// Optional divide-by-zero flag output: define NRDIV_DBZ_FLAG_EN.
package nrdiv_pkg;

    localparam int DEFAULT_W = 8;

    localparam logic [63:0] DBZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        STEP,
        CORRECT,
        OUT_Q,
        OUT_R
    } state_t;

endpackage

// File: rtl/nonrestoring_divider_addsub.sv
// Combinational N-bit adder/subtractor shared by the STEP and CORRECT phases.
// Wraps modulo 2^N; the caller sizes N so the partial remainder never overflows.
module addsub_unit #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned W-bit sequential non-restoring divider with a serial operand/result bus.
// Define NRDIV_DBZ_FLAG_EN to add the registered divide-by-zero flag output dbz.
module nonrestoring_divider
    import nrdiv_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         bgn,
    input  logic [W-1:0] ibus,
    output logic [W-1:0] obus,
    output logic         stop
`ifdef NRDIV_DBZ_FLAG_EN
    ,
    output logic         dbz
`endif
);

    state_t state, state_n;

    logic [W:0]       a, a_n;
    logic [W-1:0]     q, q_n;
    logic [W-1:0]     m, m_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [W-1:0]     obus_n;
    logic             stop_n;

    logic [W:0] a_sh;
    logic [W:0] au_a;
    logic [W:0] au_y;
    logic       au_sub;

    assign a_sh = {a[W-1:0], q[W-1]};

    // STEP uses the shifted remainder; CORRECT restores by adding M.
    always_comb begin
        au_a   = a;
        au_sub = 1'b0;
        if (state == STEP) begin
            au_a   = a_sh;
            au_sub = ~a[W];
        end
    end

    addsub_unit #(
        .N(W + 1)
    ) u_addsub (
        .a  (au_a),
        .b  ({1'b0, m}),
        .sub(au_sub),
        .y  (au_y)
    );

    always_comb begin
        state_n = state;
        a_n     = a;
        q_n     = q;
        m_n     = m;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bgn) begin
                    q_n     = ibus;
                    a_n     = '0;
                    cnt_n   = '0;
                    state_n = LOAD_M;
                end
            end
            LOAD_M: begin
                m_n = ibus;
                if (ibus == '0) begin
                    q_n     = DBZ_QUOTIENT[W-1:0];
                    a_n     = {1'b0, q};
                    state_n = OUT_Q;
                end else begin
                    state_n = STEP;
                end
            end
            STEP: begin
                a_n   = au_y;
                q_n   = {q[W-2:0], ~au_y[W]};
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(W - 1)) begin
                    state_n = CORRECT;
                end
            end
            CORRECT: begin
                if (a[W]) begin
                    a_n = au_y;
                end
                state_n = OUT_Q;
            end
            OUT_Q: begin
                state_n = OUT_R;
            end
            OUT_R: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered, so decode them from the state being entered.
    always_comb begin
        obus_n = '0;
        stop_n = 1'b0;
        unique case (1'b1)
            (state_n == OUT_Q): begin
                obus_n = q_n;
            end
            (state_n == OUT_R): begin
                obus_n = a_n[W-1:0];
                stop_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
            obus  <= '0;
            stop  <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            q     <= q_n;
            m     <= m_n;
            cnt   <= cnt_n;
            obus  <= obus_n;
            stop  <= stop_n;
        end
    end

`ifdef NRDIV_DBZ_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst_b) begin
            dbz <= 1'b0;
        end else if (state == LOAD_M && ibus == '0) begin
            dbz <= 1'b1;
        end else if (state_n == IDLE) begin
            dbz <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (W=8) against an arithmetic model.
// Covers reset, corner operands, divide-by-zero, bgn hold, back-to-back and reset abort.
module tb_nonrestoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         bgn;
    logic [W-1:0] ibus;
    logic [W-1:0] obus;
    logic         stop;
`ifdef NRDIV_DBZ_FLAG_EN
    logic         dbz;
    logic         dbzs [0:15];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] obs [0:15];
    logic         sts [0:15];

    nonrestoring_divider #(
        .W(W)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bgn  (bgn),
        .ibus (ibus),
        .obus (obus),
        .stop (stop)
`ifdef NRDIV_DBZ_FLAG_EN
        ,
        .dbz  (dbz)
`endif
    );

    always #5 clk = ~clk;

    // Drives one operation starting in the current (IDLE) cycle and records
    // obus/stop for cycles 1..last; returns at the start of cycle last+1.
    task automatic run_op(input logic [W-1:0] d, input logic [W-1:0] m,
                          input bit hold, input int last);
        for (int k = 0; k < 16; k++) begin
            obs[k] = '0;
            sts[k] = 1'b0;
        end
        bgn  = 1'b1;
        ibus = d;
        @(posedge clk); #1;
        ibus = m;
        bgn  = hold;
        for (int k = 1; k <= last; k++) begin
            obs[k] = obus;
            sts[k] = stop;
`ifdef NRDIV_DBZ_FLAG_EN
            dbzs[k] = dbz;
`endif
            @(posedge clk); #1;
            ibus = W'($urandom);
            if (k + 1 > last) bgn = 1'b0;
        end
        bgn = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        bgn   = 1'b1;
        ibus  = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obus !== 8'd0 || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: obus=%0d stop=%b, want 0 0", obus, stop);
        end
        bgn   = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obus !== 8'd0 || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: obus=%0d stop=%b, want 0 0", obus, stop);
        end
`ifdef NRDIV_DBZ_FLAG_EN
        n_checks++;
        if (dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dbz: dbz=%b, want 0", dbz);
        end
`endif
    endtask

    task automatic test_basic();
        run_op(8'd100, 8'd7, 1'b0, 12);
        for (int k = 1; k <= 10; k++) begin
            n_checks++;
            if (obs[k] !== 8'd0 || sts[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_quiet c%0d: obus=%0d stop=%b, want 0 0",
                         k, obs[k], sts[k]);
            end
        end
        n_checks++;
        if (obs[11] !== 8'd14 || sts[11] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_q: obus=%0d stop=%b, want 14 0", obs[11], sts[11]);
        end
        n_checks++;
        if (obs[12] !== 8'd2 || sts[12] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_r: obus=%0d stop=%b, want 2 1", obs[12], sts[12]);
        end
        n_checks++;
        if (obus !== 8'd0 || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: obus=%0d stop=%b, want 0 0", obus, stop);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] dv [0:4];
        logic [W-1:0] mv [0:4];
        logic [W-1:0] eq, er;
        dv = '{8'd255, 8'd5, 8'd255, 8'd0, 8'd254};
        mv = '{8'd1,   8'd9, 8'd255, 8'd3, 8'd255};
        for (int i = 0; i < 5; i++) begin
            eq = dv[i] / mv[i];
            er = dv[i] % mv[i];
            run_op(dv[i], mv[i], 1'b0, 12);
            n_checks++;
            if (obs[11] !== eq || obs[12] !== er || sts[12] !== 1'b1) begin
                n_fail++;
                $display("FAIL edge %0d/%0d: got q=%0d r=%0d stop=%b, want q=%0d r=%0d stop=1",
                         dv[i], mv[i], obs[11], obs[12], sts[12], eq, er);
            end
        end
    endtask

    task automatic test_div_by_zero();
        run_op(8'd200, 8'd0, 1'b0, 3);
        n_checks++;
        if (obs[2] !== 8'hFF || sts[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_q: obus=%h stop=%b, want ff 0", obs[2], sts[2]);
        end
        n_checks++;
        if (obs[3] !== 8'hC8 || sts[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_r: obus=%h stop=%b, want c8 1", obs[3], sts[3]);
        end
        n_checks++;
        if (obus !== 8'd0 || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_after: obus=%0d stop=%b, want 0 0", obus, stop);
        end
`ifdef NRDIV_DBZ_FLAG_EN
        n_checks++;
        if (dbzs[1] !== 1'b0 || dbzs[2] !== 1'b1 || dbzs[3] !== 1'b1 || dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_flag: c1..c4=%b%b%b%b, want 0110",
                     dbzs[1], dbzs[2], dbzs[3], dbz);
        end
`endif
        run_op(8'd50, 8'd6, 1'b0, 12);
        n_checks++;
        if (obs[11] !== 8'd8 || obs[12] !== 8'd2) begin
            n_fail++;
            $display("FAIL dbz_recover: q=%0d r=%0d, want 8 2", obs[11], obs[12]);
        end
`ifdef NRDIV_DBZ_FLAG_EN
        n_checks++;
        if (dbzs[2] !== 1'b0 || dbzs[12] !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_normal: dbz=%b/%b, want 0/0", dbzs[2], dbzs[12]);
        end
`endif
    endtask

    task automatic test_bgn_hold();
        int nstop;
        int bad;
        run_op(8'd100, 8'd7, 1'b1, 12);
        nstop = 0;
        for (int k = 1; k <= 12; k++) nstop += int'(sts[k]);
        n_checks++;
        if (obs[11] !== 8'd14 || obs[12] !== 8'd2 || nstop != 1) begin
            n_fail++;
            $display("FAIL hold_result: q=%0d r=%0d stops=%0d, want 14 2 1",
                     obs[11], obs[12], nstop);
        end
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            if (obus !== 8'd0 || stop !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_restart: %0d nonzero idle cycles, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q1, r1;
        run_op(8'd100, 8'd7, 1'b0, 12);
        q1 = obs[11];
        r1 = obs[12];
        run_op(8'd81, 8'd9, 1'b0, 12);
        n_checks++;
        if (q1 !== 8'd14 || r1 !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_first: q=%0d r=%0d, want 14 2", q1, r1);
        end
        n_checks++;
        if (obs[11] !== 8'd9 || obs[12] !== 8'd0 || sts[12] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: q=%0d r=%0d stop=%b, want 9 0 1",
                     obs[11], obs[12], sts[12]);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bgn  = 1'b1;
        ibus = 8'd100;
        @(posedge clk); #1;
        bgn  = 1'b0;
        ibus = 8'd7;
        repeat (4) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        n_checks++;
        if (obus !== 8'd0 || stop !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_now: obus=%0d stop=%b, want 0 0", obus, stop);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (obus !== 8'd0 || stop !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_idle: %0d nonzero cycles, want 0", bad);
        end
        run_op(8'd50, 8'd6, 1'b0, 12);
        n_checks++;
        if (obs[11] !== 8'd8 || obs[12] !== 8'd2 || sts[12] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_fresh: q=%0d r=%0d stop=%b, want 8 2 1",
                     obs[11], obs[12], sts[12]);
        end
    endtask

    task automatic test_random_sweep();
        logic [W-1:0] d, m, eq, er;
        int nstop;
        for (int i = 0; i < 2500; i++) begin
            d  = W'($urandom);
            m  = W'($urandom_range(1, 255));
            eq = d / m;
            er = d % m;
            run_op(d, m, 1'b0, 12);
            nstop = 0;
            for (int k = 1; k <= 12; k++) nstop += int'(sts[k]);
            n_checks++;
            if (obs[11] !== eq || obs[12] !== er || sts[12] !== 1'b1 || nstop != 1) begin
                n_fail++;
                $display("FAIL sweep %0d/%0d: q=%0d r=%0d stops=%0d, want q=%0d r=%0d stops=1",
                         d, m, obs[11], obs[12], nstop, eq, er);
            end
        end
    endtask

    initial begin
        rst_b = 1'b1;
        bgn   = 1'b0;
        ibus  = '0;
        test_reset();
        test_basic();
        test_edges();
        test_div_by_zero();
        test_bgn_hold();
        test_back_to_back();
        test_reset_mid();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
